idu_pipe: RTL
=============

# idu_pipe

Registered, parametrised instruction-decode stage for the LA32R core. It takes fetched instructions over a valid/ready handshake and decodes the arithmetic, shift, immediate, upper-immediate, load/store-word and branch/jump groups. Decoded bundles go into an in-order buffer of `DEPTH` entries, which drains to the execute stage over a second valid/ready handshake. The buffer supports synchronous flush for branch redirect and flags undecodable encodings instead of silently zeroing them.

## Interface
Parameters:
- `DEPTH`, default 2: decoded-bundle buffer entries; legal range 1..8.
- `ENABLE_BR`, default 1: when 0, branch/jump and load/store encodings decode as illegal.

Ports:
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `flush`  in  1: synchronous; empties the buffer.
- `in_valid`  in  1: fetch presents `in_inst`/`in_pc`.
- `in_ready`  out  1: stage can accept this cycle.
- `in_inst`  in  32: instruction word.
- `in_pc`  in  32: instruction address.
- `out_valid`  out  1: head bundle valid.
- `out_ready`  in  1: execute accepts the head bundle.
- `out_pc`  out  32: PC of the head bundle.
- `out_alu_op`  out  5: ALU operation code.
- `out_imm`  out  32: ALU immediate.
- `out_br_off`  out  32: branch offset, byte units, sign-extended.
- `out_rf_ra0`, `out_rf_ra1`, `out_rf_wa`  out  5 each: register-file read/write addresses.
- `out_rf_we`  out  1: register-file write enable.
- `out_alu_src0_sel`  out  1: 1 selects PC, 0 selects rf_rd0.
- `out_alu_src1_sel`  out  1: 1 selects imm, 0 selects rf_rd1.
- `out_mem_op`  out  2: 00 none, 01 ld.w, 10 st.w.
- `out_br_op`  out  4: 0 none, 1 beq, 2 bne, 3 blt, 4 bge, 5 bltu, 6 bgeu, 7 b, 8 bl, 9 jirl.
- `out_illegal`  out  1: encoding not recognised; all other control fields are 0.

## Operation
- ALU codes: ADD 00000, SUB 00010, SLT 00100, SLTU 00101, AND 01001, OR 01010, XOR 01011, SLL 01110, SRL 01111, SRA 10000.
- Field names: rd = inst[4:0], rj = inst[9:5], rk = inst[14:10].
- 3R group: add/sub/slt/sltu/and/or/xor/sll/srl/sra.w.
  - ra0 = rj, ra1 = rk, wa = rd, we = 1, src sels 0.
- 2RI12 group: slti/sltui/addi.w use sign-extended imm; andi/ori/xori use zero-extended imm.
  - ra0 = rj, src1_sel = 1.
- Shift-immediate group: slli/srli/srai.w, imm = {27'b0, inst[14:10]}.
- lu12i.w and pcaddu12i: imm = {inst[24:5], 12'b0}, ALU op ADD, src1_sel = 1.
  - lu12i.w: ra0 = 0.
  - pcaddu12i: src0_sel = 1.
- ld.w and st.w: ALU op ADD, ra0 = rj, imm = sext(inst[21:10]), src1_sel = 1.
  - ld.w: wa = rd, we = 1.
  - st.w: ra1 = rd, we = 0.
- Conditional branches beq..bgeu: ra0 = rj, ra1 = rd, we = 0, br_off = sext({inst[25:10], 2'b00}).
- b and bl: br_off = sext({inst[9:0], inst[25:10], 2'b00}).
- bl and jirl (link): src0_sel = 1, src1_sel = 1, imm = 4, ADD, we = 1.
  - bl: wa = 1.
  - jirl: wa = rd, ra0 = rj, br_off = sext({inst[25:10], 2'b00}).
- Any other word sets `out_illegal = 1`; the bundle still flows so execute can raise an exception.
- Buffer: circular FIFO with head/tail pointers mod `DEPTH` and occupancy `count` of width clog2(DEPTH+1).
  - Push = `in_valid & in_ready`.
  - Pop = `out_valid & out_ready`.
- `in_ready = (count < DEPTH) | out_ready`. Push while full is legal only together with a pop.

## Timing
- Reset (async, immediate):
  - count, head and tail = 0.
  - `out_valid` = 0; `in_ready` = 1.
  - All payload outputs = 0.
- Payload outputs are forced to 0 whenever `out_valid` = 0.
- Latency: an instruction accepted at edge N is visible at the outputs from cycle N+1. There is no combinational path from `in_*` to `out_*`.
- `out_*` hold stable while `out_valid & ~out_ready`.
- Push and pop in the same cycle: count is unchanged and the pointers advance independently. Wrap from DEPTH-1 to 0.
- Empty with push: `out_valid` rises next cycle.
- Full with no pop: `in_ready` = 0 and input is held upstream.
- `flush` at edge N: count/head/tail = 0 after N, and `out_valid` = 0 in cycle N+1.
  - A push presented in the same cycle as flush is discarded.
  - A pop in that cycle still completes.
  - Flush has priority over push and pop.
- `rst` asserted mid-transfer drops all entries regardless of the handshake in progress.

## Test plan
- Reset: assert `rst` asynchronously between edges -> outputs go to 0 immediately; `out_valid` = 0, `in_ready` = 1.
- add.w decode: push 0x00101CA4 (add.w r4,r5,r7) with `out_ready` = 1 -> next cycle `out_valid` = 1, alu_op 00000, ra0 5, ra1 7, wa 4, we 1, sels 0.
- Back-pressure (DEPTH = 2): hold `out_ready` = 0 and push 3 words.
  - Required: `in_ready` falls after the 2nd push and the 3rd word is held.
  - Then raise `out_ready` -> all 3 drain in order with correct PCs.
- Full push+pop: keep the buffer full with `in_valid` = `out_ready` = 1 for 6 cycles -> one bundle per cycle, count stays 2, pointers wrap without loss.
- Flush: with 2 entries queued, assert `flush` while also pushing -> next cycle `out_valid` = 0; the pushed word never appears.
- Branch and illegal:
  - Push bl +8 (0x54000800) -> br_op 8, br_off 0x00000008, wa 1, we 1, imm 4, src0_sel 1.
  - Push 0xFFFFFFFF -> `out_illegal` = 1, we 0.
  - With `ENABLE_BR` = 0, the bl word also gives `out_illegal` = 1.

Source files
------------

// File: rtl/idu_pipe.sv
// idu_pipe: registered LA32R instruction-decode stage.
// Decodes one instruction per accepted fetch beat into a control bundle.
// Bundles are queued in an in-order circular buffer of DEPTH entries, which
// drains to execute.
// Ports:
//   clk, rst (async, active-high), flush (sync, empties the buffer)
//   in_valid/in_ready/in_inst/in_pc    fetch-side handshake
//   out_valid/out_ready                execute-side handshake
//   out_pc, out_alu_op, out_imm, out_br_off, out_rf_ra0/ra1/wa, out_rf_we,
//   out_alu_src0_sel, out_alu_src1_sel, out_mem_op, out_br_op, out_illegal
//                                      head bundle; all zero while out_valid=0
module idu_pipe #(
  parameter int DEPTH     = 2,
  parameter bit ENABLE_BR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [4:0]  out_alu_op,
  output logic [31:0] out_imm,
  output logic [31:0] out_br_off,
  output logic [4:0]  out_rf_ra0,
  output logic [4:0]  out_rf_ra1,
  output logic [4:0]  out_rf_wa,
  output logic        out_rf_we,
  output logic        out_alu_src0_sel,
  output logic        out_alu_src1_sel,
  output logic [1:0]  out_mem_op,
  output logic [3:0]  out_br_op,
  output logic        out_illegal
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  localparam logic [4:0] ALU_ADD = 5'b00000, ALU_SUB = 5'b00010, ALU_SLT = 5'b00100,
                         ALU_SLTU = 5'b00101, ALU_AND = 5'b01001, ALU_OR = 5'b01010,
                         ALU_XOR = 5'b01011, ALU_SLL = 5'b01110, ALU_SRL = 5'b01111,
                         ALU_SRA = 5'b10000;

  typedef enum logic [3:0] {
    CL_NONE, CL_3R, CL_I12S, CL_I12Z, CL_SHI, CL_LU, CL_PCA,
    CL_LD, CL_ST, CL_BCC, CL_B, CL_BL, CL_JIRL
  } cls_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  alu_op;
    logic [31:0] imm;
    logic [31:0] br_off;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [4:0]  wa;
    logic        we;
    logic        src0_sel;
    logic        src1_sel;
    logic [1:0]  mem_op;
    logic [3:0]  br_op;
    logic        illegal;
  } bundle_t;

  cls_e       cls_s;
  logic [4:0] alu_s;
  logic [3:0] br_s;
  bundle_t    dec_s;

  logic [4:0] rd_s, rj_s, rk_s;
  assign rd_s = in_inst[4:0];
  assign rj_s = in_inst[9:5];
  assign rk_s = in_inst[14:10];

  // Opcode classification: the groups use disjoint opcode fields, so the
  // independent lookups below can never both hit.
  always_comb begin
    cls_s = CL_NONE;
    alu_s = ALU_ADD;
    br_s  = 4'd0;
    case (in_inst[31:15])
      17'h00020: begin cls_s = CL_3R;  alu_s = ALU_ADD;  end
      17'h00022: begin cls_s = CL_3R;  alu_s = ALU_SUB;  end
      17'h00024: begin cls_s = CL_3R;  alu_s = ALU_SLT;  end
      17'h00025: begin cls_s = CL_3R;  alu_s = ALU_SLTU; end
      17'h00029: begin cls_s = CL_3R;  alu_s = ALU_AND;  end
      17'h0002A: begin cls_s = CL_3R;  alu_s = ALU_OR;   end
      17'h0002B: begin cls_s = CL_3R;  alu_s = ALU_XOR;  end
      17'h0002E: begin cls_s = CL_3R;  alu_s = ALU_SLL;  end
      17'h0002F: begin cls_s = CL_3R;  alu_s = ALU_SRL;  end
      17'h00030: begin cls_s = CL_3R;  alu_s = ALU_SRA;  end
      17'h00081: begin cls_s = CL_SHI; alu_s = ALU_SLL;  end
      17'h00089: begin cls_s = CL_SHI; alu_s = ALU_SRL;  end
      17'h00091: begin cls_s = CL_SHI; alu_s = ALU_SRA;  end
      default: begin end
    endcase
    case (in_inst[31:22])
      10'h008: begin cls_s = CL_I12S; alu_s = ALU_SLT;  end
      10'h009: begin cls_s = CL_I12S; alu_s = ALU_SLTU; end
      10'h00A: begin cls_s = CL_I12S; alu_s = ALU_ADD;  end
      10'h00D: begin cls_s = CL_I12Z; alu_s = ALU_AND;  end
      10'h00E: begin cls_s = CL_I12Z; alu_s = ALU_OR;   end
      10'h00F: begin cls_s = CL_I12Z; alu_s = ALU_XOR;  end
      10'h0A2: begin cls_s = CL_LD;   alu_s = ALU_ADD;  end
      10'h0A6: begin cls_s = CL_ST;   alu_s = ALU_ADD;  end
      default: begin end
    endcase
    case (in_inst[31:25])
      7'h0A: cls_s = CL_LU;
      7'h0E: cls_s = CL_PCA;
      default: begin end
    endcase
    case (in_inst[31:26])
      6'h13: begin cls_s = CL_JIRL; br_s = 4'd9; end
      6'h14: begin cls_s = CL_B;    br_s = 4'd7; end
      6'h15: begin cls_s = CL_BL;   br_s = 4'd8; end
      6'h16: begin cls_s = CL_BCC;  br_s = 4'd1; end
      6'h17: begin cls_s = CL_BCC;  br_s = 4'd2; end
      6'h18: begin cls_s = CL_BCC;  br_s = 4'd3; end
      6'h19: begin cls_s = CL_BCC;  br_s = 4'd4; end
      6'h1A: begin cls_s = CL_BCC;  br_s = 4'd5; end
      6'h1B: begin cls_s = CL_BCC;  br_s = 4'd6; end
      default: begin end
    endcase
    // Without branch support, memory and control-flow words fall to illegal.
    if (!ENABLE_BR && (cls_s inside {CL_LD, CL_ST, CL_BCC, CL_B, CL_BL, CL_JIRL})) begin
      cls_s = CL_NONE;
    end else begin
      cls_s = cls_s;
    end
  end

  // Bundle construction from the decoded class.
  always_comb begin
    dec_s        = '0;
    dec_s.pc     = in_pc;
    dec_s.alu_op = alu_s;
    case (cls_s)
      CL_3R: begin
        dec_s.ra0 = rj_s; dec_s.ra1 = rk_s; dec_s.wa = rd_s; dec_s.we = 1'b1;
      end
      CL_I12S: begin
        dec_s.ra0 = rj_s; dec_s.wa = rd_s; dec_s.we = 1'b1; dec_s.src1_sel = 1'b1;
        dec_s.imm = {{20{in_inst[21]}}, in_inst[21:10]};
      end
      CL_I12Z: begin
        dec_s.ra0 = rj_s; dec_s.wa = rd_s; dec_s.we = 1'b1; dec_s.src1_sel = 1'b1;
        dec_s.imm = {20'b0, in_inst[21:10]};
      end
      CL_SHI: begin
        dec_s.ra0 = rj_s; dec_s.wa = rd_s; dec_s.we = 1'b1; dec_s.src1_sel = 1'b1;
        dec_s.imm = {27'b0, in_inst[14:10]};
      end
      CL_LU, CL_PCA: begin
        // lu12i.w adds to r0 (ra0 stays 0); pcaddu12i adds to the PC.
        dec_s.wa = rd_s; dec_s.we = 1'b1; dec_s.src1_sel = 1'b1;
        dec_s.src0_sel = (cls_s == CL_PCA);
        dec_s.imm = {in_inst[24:5], 12'b0};
      end
      CL_LD: begin
        dec_s.ra0 = rj_s; dec_s.wa = rd_s; dec_s.we = 1'b1; dec_s.src1_sel = 1'b1;
        dec_s.imm = {{20{in_inst[21]}}, in_inst[21:10]}; dec_s.mem_op = 2'b01;
      end
      CL_ST: begin
        dec_s.ra0 = rj_s; dec_s.ra1 = rd_s; dec_s.src1_sel = 1'b1;
        dec_s.imm = {{20{in_inst[21]}}, in_inst[21:10]}; dec_s.mem_op = 2'b10;
      end
      CL_BCC: begin
        dec_s.ra0 = rj_s; dec_s.ra1 = rd_s; dec_s.br_op = br_s;
        dec_s.br_off = {{14{in_inst[25]}}, in_inst[25:10], 2'b00};
      end
      CL_B: begin
        dec_s.br_op  = br_s;
        dec_s.br_off = {{4{in_inst[9]}}, in_inst[9:0], in_inst[25:10], 2'b00};
      end
      CL_BL: begin
        // Link: execute computes PC + 4 into r1.
        dec_s.br_op  = br_s;
        dec_s.br_off = {{4{in_inst[9]}}, in_inst[9:0], in_inst[25:10], 2'b00};
        dec_s.src0_sel = 1'b1; dec_s.src1_sel = 1'b1; dec_s.imm = 32'd4;
        dec_s.we = 1'b1; dec_s.wa = 5'd1;
      end
      CL_JIRL: begin
        dec_s.br_op  = br_s;
        dec_s.br_off = {{14{in_inst[25]}}, in_inst[25:10], 2'b00};
        dec_s.src0_sel = 1'b1; dec_s.src1_sel = 1'b1; dec_s.imm = 32'd4;
        dec_s.we = 1'b1; dec_s.wa = rd_s; dec_s.ra0 = rj_s;
      end
      default: begin
        // Unknown word: only the PC and the illegal flag travel on.
        dec_s         = '0;
        dec_s.pc      = in_pc;
        dec_s.illegal = 1'b1;
      end
    endcase
  end

  bundle_t        mem_q [DEPTH];
  bundle_t        mem_d [DEPTH];
  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic           push_s, pop_s;
  bundle_t        head_bundle_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_C) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // A full buffer still accepts when the head leaves in the same cycle.
  assign in_ready  = (count_q < DEPTH_C) | out_ready;
  assign out_valid = (count_q != '0);
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  // Buffer next-state; flush overrides both push and pop.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_s) begin
        mem_d[tail_q] = dec_s;
        tail_d        = ptr_inc(tail_q);
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        head_d = ptr_inc(head_q);
      end else begin
        head_d = head_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Head payload, zeroed while the buffer is empty.
  always_comb begin
    if (out_valid) begin
      head_bundle_s = mem_q[head_q];
    end else begin
      head_bundle_s = '0;
    end
  end

  assign out_pc           = head_bundle_s.pc;
  assign out_alu_op       = head_bundle_s.alu_op;
  assign out_imm          = head_bundle_s.imm;
  assign out_br_off       = head_bundle_s.br_off;
  assign out_rf_ra0       = head_bundle_s.ra0;
  assign out_rf_ra1       = head_bundle_s.ra1;
  assign out_rf_wa        = head_bundle_s.wa;
  assign out_rf_we        = head_bundle_s.we;
  assign out_alu_src0_sel = head_bundle_s.src0_sel;
  assign out_alu_src1_sel = head_bundle_s.src1_sel;
  assign out_mem_op       = head_bundle_s.mem_op;
  assign out_br_op        = head_bundle_s.br_op;
  assign out_illegal      = head_bundle_s.illegal;
endmodule
